// File: rtl/reg_pipe_elastic.sv
// reg_pipe_elastic: DEPTH-stage elastic register pipeline with a per-stage
// valid bit, a valid/ready handshake on both sides, bubble collapsing, a
// global freeze (enable), a synchronous flush and a registered occupancy count.
module reg_pipe_elastic #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    // Stage state: index 0 is the input side, DEPTH-1 drives the output.
    logic [DEPTH-1:0] v_reg;
    logic [DEPTH-1:0] v_next;
    logic [WIDTH-1:0] d_reg  [DEPTH];
    logic [WIDTH-1:0] d_next [DEPTH];
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    // r[i] = stage i can take a new word this cycle; r[DEPTH] is the sink.
    logic [DEPTH:0]   r;
    // Source of each stage: the upstream port for stage 0, else the stage before.
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];

    logic go;
    logic in_xfer;
    logic out_xfer;

    // Transfers only happen while running and not flushing.
    assign go = enable & ~flush;

    // Ready chain from the sink back to stage 0: a stage accepts when it is
    // empty or its own word is leaving, which is what collapses bubbles.
    always_comb begin
        r        = '0;
        r[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r[i] = ~v_reg[i] | r[i + 1];
        end
    end

    // Route each stage's source: stage 0 sees the input port.
    always_comb begin
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v_reg[i - 1];
            src_d[i] = d_reg[i - 1];
        end
    end

    // Per-stage next state. Flush clears valids but leaves data alone; data
    // only loads from a valid source so stale words never overwrite good ones.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign v_next[gi] = flush ? 1'b0
                              : ((enable & r[gi]) ? src_v[gi] : v_reg[gi]);
            assign d_next[gi] = (go & r[gi] & src_v[gi]) ? src_d[gi] : d_reg[gi];
        end
    endgenerate

    // Handshake outputs; out_data is deliberately left ungated.
    assign in_ready  = go & r[0];
    assign out_valid = go & v_reg[DEPTH - 1];
    assign out_data  = d_reg[DEPTH - 1];
    assign count     = count_reg;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Occupancy tracks the handshakes; a simultaneous push and pop cancels.
    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (in_xfer & ~out_xfer) begin
            count_next = count_reg + CW'(1);
        end else if (~in_xfer & out_xfer) begin
            count_next = count_reg - CW'(1);
        end
    end

    // State registers with asynchronous reset to the empty pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_reg     <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_reg[i] <= RESET_VAL;
            end
        end else begin
            v_reg     <= v_next;
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                d_reg[i] <= d_next[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// tb_reg_pipe_elastic: table-driven check of the elastic pipeline (DEPTH=4)
// plus hand-written sequences for async reset and a DEPTH=1 instance.
module tb_reg_pipe_elastic;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;

    // Single-stage instance
    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [7:0] s_in_data = 8'h00;
    logic       s_out_valid;
    logic       s_out_ready = 1'b0;
    logic [7:0] s_out_data;
    logic [0:0] s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_pipe_elastic #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    reg_pipe_elastic #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
        .clk(clk), .reset(reset), .enable(1'b1), .flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .count(s_count)
    );

    typedef struct {
        logic       en;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       orr;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic fl, input logic iv, input logic [7:0] id,
                       input logic orr, input logic ir, input logic ov, input logic [7:0] od,
                       input logic [2:0] cnt);
        vec_t t;
        t.en = en; t.fl = fl; t.iv = iv; t.id = id; t.orr = orr;
        t.ir = ir; t.ov = ov; t.od = od; t.cnt = cnt;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // One cycle of the single-stage instance: drive, check before the edge.
    task automatic s_vec(input int idx, input logic iv, input logic [7:0] id, input logic orr,
                         input logic ir, input logic ov, input logic [7:0] od, input logic cnt);
        s_in_valid  = iv;
        s_in_data   = id;
        s_out_ready = orr;
        @(negedge clk);
        check("d1_in_ready", idx, 32'(s_in_ready), 32'(ir));
        check("d1_out_valid", idx, 32'(s_out_valid), 32'(ov));
        check("d1_out_data", idx, 32'(s_out_data), 32'(od));
        check("d1_count", idx, 32'(s_count), 32'(cnt));
        $display("d1 step %0d: iv=%b id=%02h or=%b -> ir=%b ov=%b od=%02h cnt=%0d",
                 idx, iv, id, orr, s_in_ready, s_out_valid, s_out_data, s_count);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Latency: single 0xA5 pushed, output exactly 4 steps later for one step
        add(1,0,1,8'hA5,1, 1,0,8'h00,0);
        add(1,0,0,8'h00,1, 1,0,8'h00,1);
        add(1,0,0,8'h00,1, 1,0,8'h00,1);
        add(1,0,0,8'h00,1, 1,0,8'h00,1);
        add(1,0,0,8'h00,1, 1,1,8'hA5,1);
        add(1,0,0,8'h00,1, 1,0,8'hA5,0);
        // Streaming 0x01..0x08 back-to-back, then drain
        for (int n = 0; n < 8; n++) begin
            add(1,0,1,8'(n+1),1, 1,(n >= 4),(n >= 4) ? 8'(n-3) : 8'hA5,(n < 4) ? 3'(n) : 3'd4);
        end
        add(1,0,0,8'h00,1, 1,1,8'h05,4);
        add(1,0,0,8'h00,1, 1,1,8'h06,3);
        add(1,0,0,8'h00,1, 1,1,8'h07,2);
        add(1,0,0,8'h00,1, 1,1,8'h08,1);
        add(1,0,0,8'h00,1, 1,0,8'h08,0);
        // Full: 0x10..0x13 accepted, 0x14 held, then push+pop in one cycle
        add(1,0,1,8'h10,0, 1,0,8'h08,0);
        add(1,0,1,8'h11,0, 1,0,8'h08,1);
        add(1,0,1,8'h12,0, 1,0,8'h08,2);
        add(1,0,1,8'h13,0, 1,0,8'h08,3);
        add(1,0,1,8'h14,0, 0,1,8'h10,4);
        add(1,0,1,8'h14,0, 0,1,8'h10,4);
        add(1,0,1,8'h14,1, 1,1,8'h10,4);
        add(1,0,0,8'h00,1, 1,1,8'h11,4);
        add(1,0,0,8'h00,1, 1,1,8'h12,3);
        add(1,0,0,8'h00,1, 1,1,8'h13,2);
        add(1,0,0,8'h00,1, 1,1,8'h14,1);
        add(1,0,0,8'h00,1, 1,0,8'h14,0);
        // Bubble collapse: 0x11, two idles, 0x22; both settle in stages 3 and 2
        add(1,0,1,8'h11,0, 1,0,8'h14,0);
        add(1,0,0,8'h00,0, 1,0,8'h14,1);
        add(1,0,0,8'h00,0, 1,0,8'h14,1);
        add(1,0,1,8'h22,0, 1,0,8'h14,1);
        add(1,0,0,8'h00,0, 1,1,8'h11,2);
        add(1,0,0,8'h00,0, 1,1,8'h11,2);
        add(1,0,0,8'h00,0, 1,1,8'h11,2);
        add(1,0,0,8'h00,1, 1,1,8'h11,2);
        add(1,0,0,8'h00,1, 1,1,8'h22,1);
        add(1,0,0,8'h00,1, 1,0,8'h22,0);
        // Freeze for 3 steps with a full pipe, then resume intact
        add(1,0,1,8'h31,1, 1,0,8'h22,0);
        add(1,0,1,8'h32,1, 1,0,8'h22,1);
        add(1,0,1,8'h33,1, 1,0,8'h22,2);
        add(1,0,1,8'h34,1, 1,0,8'h22,3);
        add(0,0,1,8'h35,1, 0,0,8'h31,4);
        add(0,0,1,8'h35,1, 0,0,8'h31,4);
        add(0,0,1,8'h35,1, 0,0,8'h31,4);
        add(1,0,0,8'h00,1, 1,1,8'h31,4);
        add(1,0,0,8'h00,1, 1,1,8'h32,3);
        add(1,0,0,8'h00,1, 1,1,8'h33,2);
        add(1,0,0,8'h00,1, 1,1,8'h34,1);
        add(1,0,0,8'h00,1, 1,0,8'h34,0);
        // Flush with 3 words held (one at the output), then 0x5A exits 4 steps later
        add(1,0,1,8'h41,0, 1,0,8'h34,0);
        add(1,0,1,8'h42,0, 1,0,8'h34,1);
        add(1,0,1,8'h43,0, 1,0,8'h34,2);
        add(1,0,0,8'h00,0, 1,0,8'h34,3);
        add(1,1,1,8'h99,1, 0,0,8'h41,3);
        add(1,0,1,8'h5A,1, 1,0,8'h41,0);
        add(1,0,0,8'h00,1, 1,0,8'h41,1);
        add(1,0,0,8'h00,1, 1,0,8'h41,1);
        add(1,0,0,8'h00,1, 1,0,8'h41,1);
        add(1,0,0,8'h00,1, 1,1,8'h5A,1);
        add(1,0,0,8'h00,1, 1,0,8'h5A,0);
        // Flush while frozen still clears; the flushed word never reaches the output
        add(1,0,1,8'h66,1, 1,0,8'h5A,0);
        add(0,1,0,8'h00,1, 0,0,8'h5A,1);
        add(1,0,0,8'h00,1, 1,0,8'h5A,0);
        add(1,0,0,8'h00,1, 1,0,8'h5A,0);
        add(1,0,0,8'h00,1, 1,0,8'h5A,0);
        add(1,0,0,8'h00,1, 1,0,8'h5A,0);

        // Initial asynchronous reset
        #1 reset = 1'b1;
        #1;
        check("reset_out_valid", -1, 32'(out_valid), 32'(0));
        check("reset_count", -1, 32'(count), 32'(0));
        check("reset_out_data", -1, 32'(out_data), 32'(8'h00));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            enable    = vecs[i].en;
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].orr;
            @(negedge clk);
            check("in_ready", i, 32'(in_ready), 32'(vecs[i].ir));
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
            check("out_data", i, 32'(out_data), 32'(vecs[i].od));
            check("count", i, 32'(count), 32'(vecs[i].cnt));
            $display("step %0d: en=%b fl=%b iv=%b id=%02h or=%b -> ir=%b ov=%b od=%02h cnt=%0d",
                     i, vecs[i].en, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].orr,
                     in_ready, out_valid, out_data, count);
            @(posedge clk);
            #1;
        end

        // Mid-cycle asynchronous reset with a word at the output
        enable = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        @(posedge clk);
        #1 in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_out_valid", 100, 32'(out_valid), 32'(1));
        check("pre_reset_out_data", 100, 32'(out_data), 32'(8'h77));
        check("pre_reset_count", 100, 32'(count), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("async_reset_out_valid", 101, 32'(out_valid), 32'(0));
        check("async_reset_count", 101, 32'(count), 32'(0));
        check("async_reset_out_data", 101, 32'(out_data), 32'(8'h00));
        $display("async reset: ov=%b od=%02h cnt=%0d", out_valid, out_data, count);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("post_reset_in_ready", 102, 32'(in_ready), 32'(1));
        check("post_reset_count", 102, 32'(count), 32'(0));
        $display("reset released: ir=%b cnt=%0d", in_ready, count);

        // DEPTH=1 instance: fill, full, push+pop, drain
        @(posedge clk);
        #1;
        s_vec(0, 1, 8'hAB, 0, 1, 0, 8'h00, 0);
        s_vec(1, 1, 8'hCD, 0, 0, 1, 8'hAB, 1);
        s_vec(2, 1, 8'hCD, 1, 1, 1, 8'hAB, 1);
        s_vec(3, 0, 8'h00, 1, 1, 1, 8'hCD, 1);
        s_vec(4, 0, 8'h00, 0, 1, 0, 8'hCD, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_pipe_elastic.md
Name: reg_pipe_elastic

Overview:
- Parametrised successor to the single-enable register: a DEPTH-stage chain of WIDTH-bit registers, each stage with its own valid bit.
- Uses a valid/ready handshake on both sides, with per-stage bubble collapsing and a global enable (freeze).
- Provides a synchronous flush and an occupancy count.
- Sits between datapath blocks that need registered retiming plus elastic buffering of up to DEPTH words.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages, which is also the capacity (>=1).
- RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = normal operation; 0 = freeze all state, no transfers.
- flush  in  1  synchronous clear of all valid bits.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  upstream data.
- out_valid  out  1  word present at the output.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  data of the output stage (stage DEPTH-1).
- count  out  $clog2(DEPTH+1)  registered number of valid stages.

Behaviour:
- Stages are indexed 0 (input side) to DEPTH-1 (output side). State per stage: data d[i] and valid v[i].
- Reset (async, mid-operation included):
  - all v[i]=0 and all d[i]=RESET_VAL;
  - count=0, out_valid=0, out_data=RESET_VAL;
  - in_ready=1 as soon as reset deasserts, provided enable=1 and flush=0.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = ~v[i] | r[i+1].
  - in_ready = enable & ~flush & r[0].
  - out_valid = enable & ~flush & v[DEPTH-1].
  - out_data = d[DEPTH-1], ungated.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Valid and data must not depend on ready. out_ready -> in_ready is an allowed combinational path.
- Rising edge with enable=1 and flush=0, for each stage i (the source for stage 0 is in_valid/in_data):
  - If r[i]: v[i] <= v[i-1].
  - If r[i] & v[i-1]: d[i] <= d[i-1].
  - Otherwise d[i] and v[i] hold.
  - Data registers never load from an invalid source.
- Data moves one stage per cycle. Bubbles collapse: a valid word advances whenever the next stage is empty or advancing.
- Latency: a word accepted at edge k with an empty pipe and out_ready=1 is presented at out_valid after edge k+DEPTH-1. That is DEPTH cycles from the input handshake to the output handshake.
- Throughput: 1 word per cycle sustained.
- Full: all v=1 and out_ready=0 -> in_ready=0. If full and out_ready=1, push and pop in the same cycle are allowed and count is unchanged.
- Empty: out_valid=0; out_data holds the last value (not cleared).
- count:
  - register updated +1 on an input-only transfer, -1 on an output-only transfer, unchanged on both or neither;
  - always equals the number of v[i]=1;
  - never exceeds DEPTH and never underflows.
- enable=0:
  - in_ready=0 and out_valid=0;
  - all d, v and count hold;
  - flush still acts.
- flush=1 (priority over enable and over any transfer):
  - in_ready=0 and out_valid=0 that cycle;
  - at the edge all v<=0 and count<=0; data registers hold.
  - Input is accepted again the cycle after flush deasserts.
- DEPTH=1: a single stage. in_ready = enable & ~flush & (~v[0] | out_ready).

Test Plan:
All scenarios use WIDTH=8, DEPTH=4, RESET_VAL=0, enable=1 unless stated.
- Reset: assert reset asynchronously mid-cycle -> immediately out_valid=0, count=0, out_data=0x00. After deassert, in_ready=1.
- Latency: single push 0xA5 at edge 0 with out_ready=1 -> out_valid=1 with out_data=0xA5 exactly in cycle 4, for one cycle only; count goes 1,1,1,1,0.
- Streaming: push 0x01..0x08 back-to-back with out_ready=1 -> output 0x01..0x08 in order, no gaps, no duplicates; count holds at 4 in steady state.
- Full and pass-through:
  - out_ready=0, in_valid=1 with 0x10..0x14 -> 0x10..0x13 accepted, then in_ready=0 and count=4; 0x14 is held.
  - Then out_ready=1 -> 0x10 popped while 0x14 is pushed in the same cycle; count stays 4.
- Bubble collapse:
  - out_ready=0, push 0x11, idle 2 cycles, push 0x22 -> 0x11 in stage 3, 0x22 in stage 2, count=2.
  - Then out_ready=1 -> 0x11 and 0x22 appear on consecutive cycles.
- Freeze and flush:
  - enable=0 for 3 cycles mid-stream -> in_ready=0, out_valid=0, count and data unchanged; the stream resumes intact after enable returns to 1.
  - flush with 3 words held -> count=0 and out_valid=0 the next cycle; a new push of 0x5A exits after 4 cycles.
